// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata_o is registered on pop.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wr_en_i,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             wr_error_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             almost_empty_o,
  output logic             rd_error_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q;
  logic             wr_err_q, rd_err_q;
  logic             wr_acc, rd_acc;

  // Acceptance is judged on registered (pre-edge) flags only.
  always_comb begin
    wr_acc   = wr_en_i && !full_q;
    rd_acc   = rd_en_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= CW'(AF_LEVEL));
      ae_q     <= (count_d <= CW'(AE_LEVEL));
      wr_err_q <= wr_en_i && full_q;
      rd_err_q <= rd_en_i && empty_q;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata_o = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign rdata_o = rdata_q;
`endif

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;
  assign count_o        = count_q;

endmodule
